// File: rtl/dwconv_pkg.sv
// dwconv_pkg: width constants and loader state shared by the bias store blocks
package dwconv_pkg;
    localparam int DW_BIAS_NUM    = 32;
    localparam int DW_BIAS_ADDR_W = 5;
    localparam int DW_BIAS_W      = 32;

    typedef enum logic [1:0] {
        DW_LD_IDLE,
        DW_LD_LOAD,
        DW_LD_WRITE,
        DW_LD_DONE
    } dw_bias_ld_state_t;
endpackage

// File: rtl/dwconv_bias_loader_if.sv
// dwconv_bias_loader_if: byte stream valid/ready handshake into the bias loader
interface dwconv_bias_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bias_byte_packer.sv
// bias_byte_packer: assembles four accepted bytes into one little-endian word
module bias_byte_packer
    import dwconv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 acc,
    input  logic                 clr,
    input  logic [7:0]           din,
    output logic                 word_full,
    output logic [DW_BIAS_W-1:0] word
);
    logic [1:0] byte_cnt;

    // drop each accepted byte into its lane; lanes are simply overwritten per word
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (acc) begin
            word[{byte_cnt, 3'b000} +: 8] <= din;
            byte_cnt                      <= byte_cnt + 2'd1;
        end
    end

    assign word_full = acc && byte_cnt == 2'd3;
endmodule

// File: rtl/dwconv_bias_loader.sv
// dwconv_bias_loader: streams bias bytes into consecutive bias SRAM words
module dwconv_bias_loader
    import dwconv_pkg::*;
#(
    parameter int NUM_BIAS = DW_BIAS_NUM,
    parameter int ADDR_W   = DW_BIAS_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 abort,
    dwconv_bias_loader_if.slave  s,
    output logic [ADDR_W-1:0]    mem_adr,
    output logic [DW_BIAS_W-1:0] mem_d,
    output logic                 mem_we,
    output logic                 mem_me,
    output logic                 busy,
    output logic                 done
);
    dw_bias_ld_state_t    state, nxt;
    logic [ADDR_W-1:0]    word_cnt;
    logic [DW_BIAS_W-1:0] word;
    logic                 word_full, acc, clr, wr, last;

    assign clr  = state == DW_LD_IDLE && start;
    assign acc  = state == DW_LD_LOAD && s.valid && !abort;
    assign wr   = state == DW_LD_WRITE;
    assign last = word_cnt == ADDR_W'(NUM_BIAS - 1);

    bias_byte_packer u_pack (
        .clk       (clk),
        .rst_b     (rst_b),
        .acc       (acc),
        .clr       (clr),
        .din       (s.data),
        .word_full (word_full),
        .word      (word)
    );

    // loader state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= DW_LD_IDLE;
        else        state <= nxt;
    end

    // word address: cleared on start, advanced after each non-final write
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)          word_cnt <= '0;
        else if (clr)        word_cnt <= '0;
        else if (wr && !last) word_cnt <= word_cnt + 1'b1;
    end

    // next state; abort from any busy state wins over everything else
    always_comb begin
        nxt = state;
        case (state)
            DW_LD_IDLE:  nxt = start ? DW_LD_LOAD : DW_LD_IDLE;
            DW_LD_LOAD:  nxt = word_full ? DW_LD_WRITE : DW_LD_LOAD;
            DW_LD_WRITE: nxt = last ? DW_LD_DONE : DW_LD_LOAD;
            DW_LD_DONE:  nxt = DW_LD_IDLE;
            default:     nxt = DW_LD_IDLE;
        endcase
        if (abort && state != DW_LD_IDLE) nxt = DW_LD_IDLE;
    end

    // Moore outputs; SRAM pins are quiet outside the write cycle
    always_comb begin
        s.ready = state == DW_LD_LOAD;
        busy    = state != DW_LD_IDLE;
        done    = state == DW_LD_DONE;
        mem_we  = wr;
        mem_me  = wr;
        mem_adr = wr ? word_cnt : '0;
        mem_d   = wr ? word : '0;
    end
endmodule

// File: tb/tb_dwconv_bias_loader.sv
// tb_dwconv_bias_loader: randomized self-checking bench for the bias loader
module tb_dwconv_bias_loader;
    logic       clk = 0, rst_b = 0, start0 = 0, start1 = 0, abort = 0, valid = 0, sel = 0;
    logic [7:0] data = 0;
    logic [4:0] m_adr, m1_adr;
    logic [31:0] m_d, m1_d;
    logic       m_we, m_me, busy, done, m1_we, m1_me, busy1, done1, rdy;
    int         cyc = 0, base = 0, fall = -1, n_tests = 0, n_fail = 0;

    typedef struct {int c; int a; logic [31:0] d;} wr_t;
    wr_t        wq[$], w1q[$];
    int         dq[$], d1q[$];
    logic       busy_q = 0;
    logic [31:0] wexp[32];
    logic [7:0]  bq[128];

    dwconv_bias_loader_if bif(), bif1();
    assign bif.valid  = valid;
    assign bif.data   = data;
    assign bif1.valid = valid;
    assign bif1.data  = data;
    assign rdy = sel ? bif1.ready : bif.ready;

    dwconv_bias_loader dut (
        .clk(clk), .rst_b(rst_b), .start(start0), .abort(abort), .s(bif),
        .mem_adr(m_adr), .mem_d(m_d), .mem_we(m_we), .mem_me(m_me), .busy(busy), .done(done)
    );

    dwconv_bias_loader #(.NUM_BIAS(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .start(start1), .abort(abort), .s(bif1),
        .mem_adr(m1_adr), .mem_d(m1_d), .mem_we(m1_we), .mem_me(m1_me), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_we) wq.push_back('{c: cyc - base, a: int'(m_adr), d: m_d});
        if (done) dq.push_back(cyc - base);
        if (m1_we) w1q.push_back('{c: cyc - base, a: int'(m1_adr), d: m1_d});
        if (done1) d1q.push_back(cyc - base);
        if (busy_q && !busy) fall <= cyc - base;
        busy_q <= busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        wq.delete(); dq.delete(); w1q.delete(); d1q.delete();
        fall = -1;
    endtask

    task automatic fill(input bit rnd);
        for (int k = 0; k < 32; k++) wexp[k] = rnd ? $urandom : 32'hA500_0000 + k;
    endtask

    task automatic build();
        for (int i = 0; i < 128; i++) bq[i] = 8'(wexp[i / 4] >> (8 * (i % 4)));
    endtask

    task automatic do_start(input bit which);
        @(negedge clk);
        sel = which;
        if (which) start1 = 1; else start0 = 1;
        @(negedge clk);
        start0 = 0; start1 = 0;
        base = cyc - 1;
    endtask

    task automatic send(input int n, input int maxgap, input bit spam);
        int idx = 0, gap = 0, guard = 0;
        while (idx < n && guard < 5000) begin
            if (spam) start0 = 1'($urandom_range(1, 0));
            if (gap > 0) begin
                valid = 0;
                gap--;
            end else begin
                valid = 1;
                data  = bq[idx];
                if (rdy) begin
                    idx++;
                    gap = $urandom_range(maxgap, 0);
                end
            end
            @(negedge clk);
            guard++;
        end
        valid = 0; start0 = 0;
        check("send_count", idx, n);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || busy1) && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", g < 500, 1);
        @(negedge clk);
    endtask

    task automatic compare(input int n, input bit chk_cyc);
        check("wr_count", wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++) begin
            check($sformatf("wr_adr[%0d]", k), wq[k].a, k);
            check($sformatf("wr_d[%0d]", k), wq[k].d, wexp[k]);
            if (chk_cyc) check($sformatf("wr_cyc[%0d]", k), wq[k].c, 5 * (k + 1));
        end
        check("done_count", dq.size(), 1);
        if (chk_cyc && dq.size() > 0) check("done_cyc", dq[0], 5 * n + 1);
        if (chk_cyc) check("busy_fall", fall, 5 * n + 2);
    endtask

    task automatic run(input bit rnd, input int maxgap, input bit spam);
        clear(); fill(rnd); build();
        do_start(0);
        send(128, maxgap, spam);
        wait_idle();
        compare(32, maxgap == 0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ready"}, bif.ready, 0);
        check({p, "_adr"}, m_adr, 0);
        check({p, "_d"}, m_d, 0);
        check({p, "_we"}, m_we, 0);
        check({p, "_me"}, m_me, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_b = 1;
        run(0, 0, 0);
        clear(); fill(1); wexp[0] = 32'h1234_5678; build();
        do_start(0);
        send(4, 0, 0);
        repeat (2) @(negedge clk);
        check("order_cnt", wq.size(), 1);
        if (wq.size() > 0) begin
            check("order_adr", wq[0].a, 0);
            check("order_d", wq[0].d, 32'h1234_5678);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_idle();
        for (int r = 0; r < 2; r++) run(1, 7, 0);
        clear(); fill(1); build();
        do_start(0);
        send(14, 3, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("abort_writes", wq.size(), 3);
        check("abort_done", dq.size(), 0);
        run(1, 0, 0);
        run(1, 0, 1);
        clear(); fill(1); build();
        do_start(1);
        send(4, 0, 0);
        wait_idle();
        sel = 0;
        check("n1_count", w1q.size(), 1);
        if (w1q.size() > 0) begin
            check("n1_cyc", w1q[0].c, 5);
            check("n1_adr", w1q[0].a, 0);
            check("n1_d", w1q[0].d, wexp[0]);
        end
        check("n1_done_cnt", d1q.size(), 1);
        if (d1q.size() > 0) check("n1_done_cyc", d1q[0], 6);
        check("n1_main_idle", wq.size(), 0);
        clear(); fill(1); build();
        do_start(0);
        send(4, 0, 0);
        check("pre_rst_we", m_we, 1);
        #2 rst_b = 0;
        #1 check_reset_vals("arst");
        @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        check_reset_vals("post");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dwconv_bias_loader.md
# dwconv_bias_loader

Write-side companion of the depthwise-conv bias store. Accepts a byte stream of signed 32-bit bias words over a valid/ready handshake and assembles each group of four bytes, little-endian. Writes each assembled word into consecutive addresses of the single-port bias SRAM through its ADR/D/WE/ME pins. Owns the SRAM port while `busy` is high, which keeps the bias selector idle during loading; pulses `done` when the last word has been written.

## Interface
- NUM_BIAS, 32, number of bias words per load; legal range 1..32
- ADDR_W, 5, SRAM address width
- clk  input  1  rising-edge clock, shared with the SRAM
- rst_b  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE without `done`
- in_valid  input  1  byte on `in_data` is valid
- in_data  input  8  bias byte; first byte of each word is bits [7:0]
- in_ready  output  1  loader accepts a byte this cycle
- mem_adr  output  ADDR_W  SRAM address (ADR)
- mem_d  output  32  SRAM write data (D)
- mem_we  output  1  SRAM write enable (WE)
- mem_me  output  1  SRAM memory enable (ME)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final write

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE. All outputs are Moore: decoded from registered state and datapath only.
- **IDLE**
  - `in_ready`=0, `busy`=0, all mem_* signals 0.
  - `start`=1 moves to LOAD and clears `byte_cnt` (2 bit) and `word_cnt` (ADDR_W bit).
- **LOAD**
  - `in_ready`=1.
  - Each accepted byte (`in_valid & in_ready`) is written into lane `byte_cnt` of the 32-bit assembly register, then `byte_cnt` increments.
  - Acceptance with `byte_cnt`==3 moves to WRITE. `byte_cnt` wraps to 0.
- **WRITE** (exactly one cycle)
  - `in_ready`=0, `mem_me`=1, `mem_we`=1, `mem_adr`=`word_cnt`, `mem_d`=assembly register.
  - If `word_cnt`==NUM_BIAS-1, go to DONE.
  - Otherwise increment `word_cnt` and return to LOAD.
- **DONE**: `done`=1 and `busy`=1 for one cycle, then IDLE.
- `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - If asserted in WRITE, the write in that cycle still completes.
  - A partially assembled word is discarded and no further writes occur.
  - `abort` has priority over `start` and over byte acceptance.
- `start` outside IDLE is ignored, with no restart and no error.
- `in_valid` is ignored outside LOAD. Bytes offered while `in_ready`=0 are not consumed; the upstream must hold them.
- The assembly register is not cleared between words. Every lane is overwritten before each write.
- Asynchronous reset mid-load:
  - State goes to IDLE; all outputs and counters go to 0.
  - SRAM contents are undefined and a full reload is required.
- Outside WRITE, `mem_d` and `mem_adr` are 0. `mem_we` and `mem_me` are never high outside WRITE.

## Timing
- Reset values: `in_ready`=0, `mem_adr`=0, `mem_d`=0, `mem_we`=0, `mem_me`=0, `busy`=0, `done`=0.
- `start` sampled at edge 0: `busy` and `in_ready` are high from cycle 1.
- With `in_valid` held high continuously, each word costs 5 cycles (4 accept + 1 write).
  - Writes occur in cycles 5, 10, …, 5·NUM_BIAS.
  - `done` is high in cycle 5·NUM_BIAS+1, so cycle 161 for NUM_BIAS=32.
  - `busy` falls in cycle 5·NUM_BIAS+2.
- Back-pressure: `in_ready` is low only in IDLE, WRITE and DONE; no bubbles occur inside LOAD.
- SRAM write latency is one edge: data is captured at the end of the WRITE cycle.

## Structure
- Shared package `dwconv_pkg` holds:
  - `DW_BIAS_NUM`=32, `DW_BIAS_ADDR_W`=5, `DW_BIAS_W`=32
  - the loader state enum `dw_bias_ld_state_t`
- The bias selector uses the same width constants from that package.
- One natural sub-module: `bias_byte_packer`.
  - Holds `byte_cnt` and the assembly register.
  - Inputs: accept strobe, byte, clear.
  - Outputs: `word_full` (4th byte accepted) and the 32-bit word.
- The FSM, `word_cnt` and SRAM pin drive stay in the top module.

## Test plan
- Reset, then `start`, then 128 bytes at full rate, with word k = 0xA5000000+k:
  - writes occur at addresses 0..31 in cycles 5,10,…,160 with matching `mem_d`;
  - `done` pulses once at cycle 161;
  - `busy` is 0 from cycle 162.
- Byte-order check: bytes 0x78,0x56,0x34,0x12 must produce `mem_d`=0x12345678 at `mem_adr`=0.
- Random `in_valid` gaps of 0–7 cycles:
  - identical address/data write sequence to the full-rate case;
  - `mem_we` high exactly 32 times;
  - no byte is lost or duplicated.
- `abort` after 2 bytes of word 3:
  - no write to address 3;
  - `busy` is 0 next cycle and `done` never pulses;
  - a following `start` reloads from address 0.
- `start` pulsed during LOAD and during WRITE: no effect on counters or the write sequence; NUM_BIAS=1 yields one write at cycle 5 and `done` at cycle 6.
- `rst_b` asserted asynchronously mid-WRITE: `mem_we` and `mem_me` drop immediately without waiting for a clock edge, and all outputs read their reset values.
